// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants and types for the multiplexed 7-segment scan decoder.
// Holds the active-low segment patterns for digits 0..9, the blank/invalid
// codes, the scan FSM state type and small helpers for the digit strobes.
// Segment bit order is bit6=a ... bit0=g.

package seg7_pkg;

    localparam int SEG_W      = 7;
    localparam int AN_W       = 4;
    localparam int CODE_W     = 4;
    localparam int NUM_DIGITS = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [CODE_W-1:0] CODE_BLANK   = 4'hF;
    localparam logic [CODE_W-1:0] CODE_INVALID = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_e;

    // True when exactly one strobe is driven low.
    function automatic logic an_one_hot_low(input logic [AN_W-1:0] an);
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Digit index of the low strobe; only meaningful when an_one_hot_low().
    function automatic logic [1:0] an_index(input logic [AN_W-1:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// seg7_scan_decoder_if
// Bundles the scanned display bus and the decoded result.
//   seg        : multiplexed segments, active-low (bit6=a ... bit0=g)
//   an         : digit strobes, active-low, one low bit selects digit 0..3
//   digits     : decoded codes, digit i at bits 4i+3:4i
//   err        : per-digit flag, last capture was an unrecognised pattern
//   valid      : a full frame has completed and no timeout since
//   frame_done : one-cycle pulse when all four digits have been captured
// master drives the display bus, slave is the decoder.

interface seg7_scan_decoder_if;
    import seg7_pkg::*;

    logic [SEG_W-1:0]               seg;
    logic [AN_W-1:0]                an;
    logic [NUM_DIGITS*CODE_W-1:0]   digits;
    logic [NUM_DIGITS-1:0]          err;
    logic                           valid;
    logic                           frame_done;

    modport master (
        output seg, an,
        input  digits, err, valid, frame_done
    );

    modport slave (
        input  seg, an,
        output digits, err, valid, frame_done
    );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode
// Combinational segment-pattern to digit-code decoder.
//   seg     : active-low segment pattern (bit6=a ... bit0=g)
//   code    : 0..9, CODE_BLANK for all-off, CODE_INVALID otherwise
//   invalid : high only for unrecognised patterns (blank is legal)

module seg7_decode
    import seg7_pkg::*;
(
    input  logic [SEG_W-1:0]  seg,
    output logic [CODE_W-1:0] code,
    output logic              invalid
);

    always_comb begin
        code    = CODE_INVALID;
        invalid = 1'b1;
        case (seg)
            SEG_0:     begin code = 4'd0;       invalid = 1'b0; end
            SEG_1:     begin code = 4'd1;       invalid = 1'b0; end
            SEG_2:     begin code = 4'd2;       invalid = 1'b0; end
            SEG_3:     begin code = 4'd3;       invalid = 1'b0; end
            SEG_4:     begin code = 4'd4;       invalid = 1'b0; end
            SEG_5:     begin code = 4'd5;       invalid = 1'b0; end
            SEG_6:     begin code = 4'd6;       invalid = 1'b0; end
            SEG_7:     begin code = 4'd7;       invalid = 1'b0; end
            SEG_8:     begin code = 4'd8;       invalid = 1'b0; end
            SEG_9:     begin code = 4'd9;       invalid = 1'b0; end
            SEG_BLANK: begin code = CODE_BLANK; invalid = 1'b0; end
            default:   ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Recovers the four digit codes from a multiplexed, active-low 7-segment
// display bus. A digit is captured once seg/an have been stable for
// STABLE_CYCLES registered samples; four distinct captures form a frame.
//   clk   : single rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : seg7_scan_decoder_if.slave (seg/an in, digits/err/valid/frame_done out)
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | sample has no single low strobe; count held at 0
// ST_SETTLE | one-hot sample, counting identical consecutive samples
// ST_HELD   | digit captured, waiting for the sample to change

module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_decoder_if.slave bus
);

    localparam int                TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]        STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]   TO_MAX     = TO_W'(TIMEOUT_CYCLES);

    state_e                        state_q, state_d;

    logic [SEG_W-1:0]              seg_q, seg_d;
    logic [AN_W-1:0]               an_q, an_d;
    logic [SEG_W-1:0]              prev_seg_q, prev_seg_d;
    logic [AN_W-1:0]               prev_an_q, prev_an_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic [TO_W-1:0]               to_cnt_q, to_cnt_d;
    logic [NUM_DIGITS-1:0]         mask_q, mask_d;
    logic [NUM_DIGITS*CODE_W-1:0]  digits_q, digits_d;
    logic [NUM_DIGITS-1:0]         err_q, err_d;
    logic                          valid_q, valid_d;
    logic                          frame_done_q, frame_done_d;

    logic [CODE_W-1:0]             dec_code;
    logic                          dec_invalid;
    logic                          sample_one_hot;
    logic                          sample_same;
    logic                          stable_hit;
    logic [1:0]                    sel;

    seg7_decode u_decode (
        .seg     (seg_q),
        .code    (dec_code),
        .invalid (dec_invalid)
    );

    assign sample_one_hot = an_one_hot_low(an_q);
    assign sample_same    = (seg_q == prev_seg_q) && (an_q == prev_an_q);
    assign sel            = an_index(an_q);

    // Capture fires on the sample that brings the count up to STABLE_CYCLES.
    assign stable_hit = (state_q == ST_SETTLE) && sample_one_hot && sample_same
                        && (cnt_q >= STABLE_MAX - 8'd1);

    // Input register and one-cycle-delayed copy used for change detection.
    assign seg_d      = bus.seg;
    assign an_d       = bus.an;
    assign prev_seg_d = seg_q;
    assign prev_an_d  = an_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (sample_one_hot) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!sample_one_hot)  state_d = ST_IDLE;
                else if (stable_hit)  state_d = ST_HELD;
            end
            ST_HELD: begin
                if (!sample_same) state_d = sample_one_hot ? ST_SETTLE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        cnt_d        = cnt_q;
        to_cnt_d     = to_cnt_q;
        mask_d       = mask_q;
        digits_d     = digits_q;
        err_d        = err_q;
        valid_d      = valid_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = sample_one_hot ? 8'd1 : 8'd0;
            end
            ST_SETTLE: begin
                if (!sample_one_hot)      cnt_d = 8'd0;
                else if (!sample_same)    cnt_d = 8'd1;
                else if (cnt_q != STABLE_MAX) cnt_d = cnt_q + 8'd1;
            end
            ST_HELD: begin
                if (!sample_same) cnt_d = sample_one_hot ? 8'd1 : 8'd0;
            end
            default: cnt_d = 8'd0;
        endcase

        if (stable_hit) begin
            digits_d[{sel, 2'b00} +: CODE_W] = dec_code;
            err_d[sel]                       = dec_invalid;
            mask_d                           = mask_q | (4'b0001 << sel);
            to_cnt_d                         = '0;
            if (mask_d == 4'b1111) begin
                frame_done_d = 1'b1;
                valid_d      = 1'b1;
                mask_d       = '0;
            end
        end else begin
            if (to_cnt_q != TO_MAX) to_cnt_d = to_cnt_q + 1'b1;
            // Timeout drops the frame but keeps the last decoded digits.
            if (to_cnt_d == TO_MAX) begin
                valid_d = 1'b0;
                mask_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q        <= SEG_BLANK;
            an_q         <= 4'hF;
            prev_seg_q   <= SEG_BLANK;
            prev_an_q    <= 4'hF;
            cnt_q        <= '0;
            to_cnt_q     <= '0;
            mask_q       <= '0;
            digits_q     <= 16'hFFFF;
            err_q        <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            prev_seg_q   <= prev_seg_d;
            prev_an_q    <= prev_an_d;
            cnt_q        <= cnt_d;
            to_cnt_q     <= to_cnt_d;
            mask_q       <= mask_d;
            digits_q     <= digits_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.digits     = digits_q;
    assign bus.err        = err_q;
    assign bus.valid      = valid_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, 4: consecutive identical samples (seg and an) required before a digit is captured; legal range 2..255.
REQ-002 Parameter TIMEOUT_CYCLES, 100000: cycles without any capture before valid drops; legal range > 4*STABLE_CYCLES.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 seg  input  7  multiplexed segment bus, active-low, bit6=a ... bit0=g.
REQ-006 an  input  4  digit strobes, active-low; exactly one low bit selects digit 0..3.
REQ-007 digits  output  16  decoded codes, digit i at bits 4i+3:4i.
REQ-008 err  output  4  err[i]=1 when the last capture of digit i was an unrecognised pattern.
REQ-009 valid  output  1  high after a full frame completes; low after timeout or reset.
REQ-010 frame_done  output  1  one-cycle pulse when all four digits are captured since the last frame.

Function
REQ-011 seg and an shall be registered once on input; all later logic uses the registered sample.
REQ-012 Decode table: 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111111->4'hF (blank, err 0); any other pattern->4'hE with err 1.
REQ-013 States: IDLE (an not one-hot-low), SETTLE (counting stable samples), HELD (digit captured, waiting for sample change).
REQ-014 IDLE->SETTLE when sample is one-hot-low, with stable count=1; in IDLE the count is 0 and nothing is captured; all-high or multi-low an is not an error.
REQ-015 In SETTLE, a sample equal to the previous increments the count; a differing one-hot sample restarts the count at 1; a non-one-hot sample goes to IDLE.
REQ-016 When the count reaches STABLE_CYCLES, the selected digit field and err bit shall be updated and the state goes to HELD; the count saturates and never wraps.
REQ-017 In HELD, further identical samples cause no recapture; any change goes to SETTLE (one-hot) or IDLE (otherwise).
REQ-018 Latency: inputs held constant from cycle t -> digits/err update visible in cycle t+STABLE_CYCLES+1.
REQ-019 A 4-bit seen mask shall set bit i on each capture of digit i; recapture of an already-seen digit overwrites the field without affecting the mask.
REQ-020 When the mask becomes 4'b1111, frame_done pulses in the same cycle the last digit update is visible, valid is set, and the mask clears.
REQ-021 Timeout counter resets on every capture, otherwise increments and saturates; reaching TIMEOUT_CYCLES clears valid and the mask; digits and err hold their values.
REQ-022 Capture and timeout in the same cycle: the capture wins, and the timeout counter resets.

Reset
REQ-023 With rst_n low at a clock edge: digits=16'hFFFF, err=0, valid=0, frame_done=0, state IDLE, counters 0, mask 0, input register cleared to seg=7'h7F, an=4'hF.
REQ-024 Reset mid-scan shall discard any partial frame; the next frame_done requires four fresh captures.

Structure
REQ-025 Package seg7_pkg shall hold the ten digit pattern constants, SEG_BLANK=7'h7F, CODE_BLANK=4'hF, CODE_INVALID=4'hE, and the state enum.
REQ-026 Pattern-to-code decode shall be a combinational sub-module seg7_decode (in: seg[6:0]; out: code[3:0], invalid).

Verification (STABLE_CYCLES=4, TIMEOUT_CYCLES=200)
REQ-027 Scan 1,2,3,4 on an=1110,1101,1011,0111 with each digit held 8 cycles -> digits=16'h4321, err=0, exactly one frame_done pulse, valid=1.
REQ-028 Digit 0 pattern toggles 1->7 after 2 cycles, then holds 7 -> no capture of 1; digits[3:0]=7 exactly 5 cycles after 7 is first applied.
REQ-029 Digit 2 shows 7'b1010101, then later 7'b1111111 -> digits[11:8]=E with err[2]=1, then F with err[2]=0.
REQ-030 an=4'b0000 or 4'b1111 for 250 cycles after a valid frame -> no captures, valid falls at timeout, digits unchanged.
REQ-031 rst_n low for 1 cycle after three digits are captured -> reset values; one more digit produces no frame_done; four captures produce frame_done.
REQ-032 Final capture of a frame lands in the timeout cycle -> frame_done=1, valid stays 1, timeout counter restarts.
